stream_trace_buffer: RTL and testbench



---
 rtl/stream_trace_buffer.sv | 231 +++++++++++++++++++++++
 tb/tb_stream_trace_buffer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_trace_buffer.sv
// Trace capture / stream serializer sharing one circular word memory.
// Stream mode is compiled in only when STB_STREAM_MODE_EN is defined.
module stream_trace_buffer #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 16,
  parameter int LANES      = 8,
  parameter int DELAY_BITS = 3,
  localparam int PW        = $clog2(DEPTH)
) (
  input  logic             CLK_I,
  input  logic             RST_NI,
  input  logic             STATUS_READY_I,
  output logic             STATUS_VALID_O,
  output logic [PW:0]      STATUS_O,
  output logic             CONTROL_READY_O,
  input  logic             CONTROL_VALID_I,
  input  logic [5:0]       CONTROL_I,
  input  logic             DATA_READY_I,
  output logic             DATA_VALID_O,
  output logic [WIDTH-1:0] DATA_O,
  output logic             DATA_READY_O,
  input  logic             DATA_VALID_I,
  input  logic [WIDTH-1:0] DATA_I,
  input  logic             FPGA_TRIG_I,
  input  logic [LANES-1:0] FPGA_TRACE_I,
  output logic             FPGA_WRITE_VALID_O,
  input  logic             FPGA_READ_I,
  output logic [LANES-1:0] FPGA_STREAM_O,
  output logic             FPGA_TRIG_O
);
  localparam int LOG_LANES = $clog2(LANES);
  localparam int SW        = $clog2(WIDTH) + 1;
  localparam int PRODW     = DELAY_BITS + PW + 1;

  typedef enum logic [2:0] {IDLE, CAPTURE, POST, DONE, STREAM} state_t;

  state_t           r_state;
  logic [5:0]       r_ctrl;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_word;
  logic [SW-1:0]    r_step;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_eventPos;
  logic [PW:0]      r_rdCnt;
  logic [PW:0]      r_fifoCnt;
  logic [PW:0]      r_remain;
  logic             r_trgEvent;
  logic             r_trigOut;
  logic             r_writeValid;
  logic             r_statusValid;
  logic             r_dataValid;

  logic [1:0]       w_nLog;
  logic [LANES-1:0] w_laneMask;
  logic [LANES-1:0] w_lanes;
  logic [SW-1:0]    w_stepsPerWord;
  logic [SW-1:0]    w_bitPos;
  logic             w_lastStep;
  logic [WIDTH-1:0] w_fill;
  logic [PRODW-1:0] w_postProd;
  logic [PW-1:0]    w_postWords;
  logic [PW:0]      w_remainInit;
  logic [PW-1:0]    w_rdAddr;
  logic [WIDTH-1:0] w_rdWord;
  logic             w_capturing;
  logic             w_memWe;
  logic [WIDTH-1:0] w_memData;
  logic             w_popStep;
  logic             w_popWord;
  logic             w_push;
  logic             w_unused;

  // Active lane count is 2^trg_num_traces, clamped to the physical lane count.
  always_comb begin
    w_nLog = r_ctrl[2:1];
    if (int'(r_ctrl[2:1]) > LOG_LANES) w_nLog = 2'(LOG_LANES);
    w_laneMask = '0;
    for (int j = 0; j < LANES; j++) w_laneMask[j] = (j < (1 << w_nLog));
  end

  assign w_stepsPerWord = SW'(WIDTH >> w_nLog);
  assign w_bitPos       = r_step << w_nLog;
  assign w_lastStep     = (r_step == w_stepsPerWord - SW'(1));
  assign w_lanes        = FPGA_TRACE_I & w_laneMask;
  assign w_fill         = r_word | (WIDTH'(w_lanes) << w_bitPos);

  assign w_postProd   = (PRODW'(r_ctrl[5:3]) + PRODW'(1)) * PRODW'(DEPTH - 1);
  assign w_postWords  = PW'(w_postProd >> DELAY_BITS);
  assign w_remainInit = (PW+1)'(w_postWords) + (PW+1)'(1) - (PW+1)'(w_lastStep);

  // Readout walks oldest-first from the write pointer; the FIFO reads from its own pointer.
  assign w_rdAddr = (r_state == DONE) ? r_wptr + r_rdCnt[PW-1:0] : r_rdCnt[PW-1:0];
  assign w_rdWord = r_mem[w_rdAddr];

  assign w_capturing = (r_state == CAPTURE) || (r_state == POST);
  assign w_memWe     = !CONTROL_VALID_I && ((w_capturing && w_lastStep) || w_push);
  assign w_memData   = w_capturing ? w_fill : DATA_I;

`ifdef STB_STREAM_MODE_EN
  logic             w_streamMode;
  logic [WIDTH-1:0] w_rdShift;

  assign w_streamMode  = (r_state == STREAM);
  assign w_popStep     = w_streamMode && FPGA_READ_I && (r_fifoCnt != '0);
  assign w_popWord     = w_popStep && w_lastStep;
  assign DATA_READY_O  = w_streamMode && ((r_fifoCnt != (PW+1)'(DEPTH)) || w_popWord);
  assign w_push        = DATA_READY_O && DATA_VALID_I;
  assign w_rdShift     = w_rdWord >> w_bitPos;
  assign FPGA_STREAM_O = w_popStep ? (w_rdShift[LANES-1:0] & w_laneMask) : '0;
  assign w_unused      = ^{STATUS_READY_I, r_ctrl[0], w_rdShift[WIDTH-1:LANES]};
`else
  assign w_popStep     = 1'b0;
  assign w_popWord     = 1'b0;
  assign w_push        = 1'b0;
  assign DATA_READY_O  = 1'b0;
  assign FPGA_STREAM_O = '0;
  assign w_unused      = ^{STATUS_READY_I, r_ctrl[0], DATA_VALID_I, FPGA_READ_I};
`endif

  always_ff @(posedge CLK_I) begin
    if (w_memWe) r_mem[r_wptr] <= w_memData;
  end

  // A control write always wins, including over a same-cycle trigger.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      r_state       <= IDLE;
      r_ctrl        <= '0;
      r_word        <= '0;
      r_step        <= '0;
      r_wptr        <= '0;
      r_eventPos    <= '0;
      r_rdCnt       <= '0;
      r_fifoCnt     <= '0;
      r_remain      <= '0;
      r_trgEvent    <= 1'b0;
      r_trigOut     <= 1'b0;
      r_writeValid  <= 1'b0;
      r_statusValid <= 1'b0;
      r_dataValid   <= 1'b0;
    end else begin
      r_trigOut <= 1'b0;
      if (CONTROL_VALID_I) begin
        r_ctrl        <= CONTROL_I;
        r_word        <= '0;
        r_step        <= '0;
        r_wptr        <= '0;
        r_eventPos    <= '0;
        r_rdCnt       <= '0;
        r_fifoCnt     <= '0;
        r_remain      <= '0;
        r_trgEvent    <= 1'b0;
        r_statusValid <= 1'b0;
        r_dataValid   <= 1'b0;
`ifdef STB_STREAM_MODE_EN
        r_state      <= CONTROL_I[0] ? STREAM : CAPTURE;
        r_writeValid <= !CONTROL_I[0];
`else
        r_state      <= CAPTURE;
        r_writeValid <= 1'b1;
`endif
      end else begin
        unique case (r_state)
          CAPTURE, POST: begin
            if (w_lastStep) begin
              r_word <= '0;
              r_step <= '0;
              r_wptr <= r_wptr + PW'(1);
            end else begin
              r_word <= w_fill;
              r_step <= r_step + SW'(1);
            end
            if (r_state == CAPTURE) begin
              if (FPGA_TRIG_I) begin
                r_trgEvent <= 1'b1;
                r_eventPos <= r_wptr;
                r_trigOut  <= 1'b1;
                r_remain   <= w_remainInit;
                if (w_remainInit == '0) begin
                  r_state       <= DONE;
                  r_writeValid  <= 1'b0;
                  r_statusValid <= 1'b1;
                  r_dataValid   <= 1'b1;
                end else begin
                  r_state <= POST;
                end
              end
            end else if (w_lastStep) begin
              if (r_remain == (PW+1)'(1)) begin
                r_state       <= DONE;
                r_writeValid  <= 1'b0;
                r_statusValid <= 1'b1;
                r_dataValid   <= 1'b1;
              end
              r_remain <= r_remain - (PW+1)'(1);
            end
          end
          DONE: begin
            if (DATA_READY_I && r_dataValid) begin
              r_rdCnt <= r_rdCnt + (PW+1)'(1);
              if (r_rdCnt == (PW+1)'(DEPTH - 1)) r_dataValid <= 1'b0;
            end
          end
          STREAM: begin
            if (w_popStep) begin
              if (w_lastStep) begin
                r_step  <= '0;
                r_rdCnt <= r_rdCnt + (PW+1)'(1);
              end else begin
                r_step <= r_step + SW'(1);
              end
            end
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_push && !w_popWord) r_fifoCnt <= r_fifoCnt + (PW+1)'(1);
            else if (!w_push && w_popWord) r_fifoCnt <= r_fifoCnt - (PW+1)'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign CONTROL_READY_O    = 1'b1;
  assign STATUS_VALID_O     = r_statusValid;
  assign STATUS_O           = {r_eventPos, r_trgEvent};
  assign DATA_VALID_O       = r_dataValid;
  assign DATA_O             = r_dataValid ? w_rdWord : '0;
  assign FPGA_WRITE_VALID_O = r_writeValid;
  assign FPGA_TRIG_O        = r_trigOut;

endmodule

// File: tb/tb_stream_trace_buffer.sv
// Scoreboard bench for stream_trace_buffer: trace capture/readout, trigger timing and
// (with STB_STREAM_MODE_EN) stream serialization.
module tb_stream_trace_buffer;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int LANES = 8;
  localparam int PW    = 4;

  logic             CLK_I = 1'b0;
  logic             RST_NI;
  logic             STATUS_READY_I;
  logic             STATUS_VALID_O;
  logic [PW:0]      STATUS_O;
  logic             CONTROL_READY_O;
  logic             CONTROL_VALID_I;
  logic [5:0]       CONTROL_I;
  logic             DATA_READY_I;
  logic             DATA_VALID_O;
  logic [WIDTH-1:0] DATA_O;
  logic             DATA_READY_O;
  logic             DATA_VALID_I;
  logic [WIDTH-1:0] DATA_I;
  logic             FPGA_TRIG_I;
  logic [LANES-1:0] FPGA_TRACE_I;
  logic             FPGA_WRITE_VALID_O;
  logic             FPGA_READ_I;
  logic [LANES-1:0] FPGA_STREAM_O;
  logic             FPGA_TRIG_O;

  int compareCount  = 0;
  int mismatchCount = 0;

  logic [31:0] expQ[$];
  logic [31:0] modelMem [DEPTH];
  int          modelWptr;
  int          modelEventPos;
  int          modelRemain;
  int          modelP;
  bit          modelCapturing;
  bit          modelTrigged;

  stream_trace_buffer dut (
    .CLK_I(CLK_I), .RST_NI(RST_NI),
    .STATUS_READY_I(STATUS_READY_I), .STATUS_VALID_O(STATUS_VALID_O), .STATUS_O(STATUS_O),
    .CONTROL_READY_O(CONTROL_READY_O), .CONTROL_VALID_I(CONTROL_VALID_I), .CONTROL_I(CONTROL_I),
    .DATA_READY_I(DATA_READY_I), .DATA_VALID_O(DATA_VALID_O), .DATA_O(DATA_O),
    .DATA_READY_O(DATA_READY_O), .DATA_VALID_I(DATA_VALID_I), .DATA_I(DATA_I),
    .FPGA_TRIG_I(FPGA_TRIG_I), .FPGA_TRACE_I(FPGA_TRACE_I),
    .FPGA_WRITE_VALID_O(FPGA_WRITE_VALID_O), .FPGA_READ_I(FPGA_READ_I),
    .FPGA_STREAM_O(FPGA_STREAM_O), .FPGA_TRIG_O(FPGA_TRIG_O)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  function automatic logic [31:0] pattern(input int batch, input int i);
    logic [31:0] v;
    v = 32'(i) * 32'h01010101;
    if (batch != 0) v = v ^ 32'hA0B0C0D0;
    return v;
  endfunction

  // One control handshake; the model restarts its pointers like the buffer does.
  task automatic applyStimulus(input logic [5:0] ctrl, input logic trig);
    CONTROL_I       = ctrl;
    CONTROL_VALID_I = 1'b1;
    FPGA_TRIG_I     = trig;
    tick();
    CONTROL_VALID_I = 1'b0;
    FPGA_TRIG_I     = 1'b0;
    modelWptr     = 0;
    modelTrigged  = 1'b0;
    modelEventPos = 0;
    modelP        = ((int'(ctrl[5:3]) + 1) * (DEPTH - 1)) >> 3;
`ifdef STB_STREAM_MODE_EN
    modelCapturing = !ctrl[0];
`else
    modelCapturing = 1'b1;
`endif
  endtask

  task automatic captureWord(input logic [31:0] value, input bit trig);
    bit expPulse;
    expPulse = trig && modelCapturing && !modelTrigged;
    if (expPulse) begin
      modelTrigged  = 1'b1;
      modelEventPos = modelWptr;
      modelRemain   = modelP + 1;
    end
    for (int k = 0; k < WIDTH / LANES; k++) begin
      FPGA_TRACE_I = value[k*8 +: 8];
      FPGA_TRIG_I  = trig && (k == 0);
      tick();
      if (trig && k == 0) checkOutput("trigPulse", 32'(FPGA_TRIG_O), 32'(expPulse));
      if (trig && k == 1) checkOutput("trigPulseEnd", 32'(FPGA_TRIG_O), 32'd0);
    end
    FPGA_TRIG_I = 1'b0;
    if (modelCapturing) begin
      modelMem[modelWptr] = value;
      modelWptr = (modelWptr + 1) % DEPTH;
      if (modelTrigged) begin
        modelRemain--;
        if (modelRemain == 0) modelCapturing = 1'b0;
      end
    end
    checkOutput("writeValid", 32'(FPGA_WRITE_VALID_O), 32'(modelCapturing));
    checkOutput("statusValid", 32'(STATUS_VALID_O), 32'(modelTrigged && !modelCapturing));
  endtask

  task automatic runTrace(input logic [2:0] delay, input int preWords);
    applyStimulus({delay, 2'd3, 1'b0}, 1'b0);
    checkOutput("writeValidStart", 32'(FPGA_WRITE_VALID_O), 32'd1);
    for (int i = 0; i < preWords; i++) captureWord(pattern(0, i), 1'b0);
    for (int i = 0; i < DEPTH; i++) captureWord(pattern(1, i), i == 0);
    checkOutput("status", 32'(STATUS_O), {27'd0, 4'(modelEventPos), 1'b1});
    checkOutput("dataValidDone", 32'(DATA_VALID_O), 32'd1);
    for (int i = 0; i < DEPTH; i++) expQ.push_back(modelMem[(modelWptr + i) % DEPTH]);
  endtask

  task automatic readWords(input int count);
    int got;
    int budget;
    logic [31:0] exp;
    got = 0;
    budget = 0;
    DATA_READY_I = 1'b1;
    while (got < count && budget < 64) begin
      if (DATA_VALID_O) begin
        exp = expQ.pop_front();
        checkOutput("readData", DATA_O, exp);
        got++;
      end
      tick();
      budget++;
    end
    DATA_READY_I = 1'b0;
    if (got < count) checkOutput("readTimeout", 32'(got), 32'(count));
  endtask

  initial begin
    logic [31:0] exp;
    RST_NI = 1'b0;
    STATUS_READY_I = 1'b0; CONTROL_VALID_I = 1'b0; CONTROL_I = '0;
    DATA_READY_I = 1'b0; DATA_VALID_I = 1'b0; DATA_I = '0;
    FPGA_TRIG_I = 1'b0; FPGA_TRACE_I = '0; FPGA_READ_I = 1'b0;
    for (int i = 0; i < DEPTH; i++) modelMem[i] = 'x;

    repeat (2) @(negedge CLK_I);
    checkOutput("rstStatusValid", 32'(STATUS_VALID_O), 32'd0);
    checkOutput("rstDataValid", 32'(DATA_VALID_O), 32'd0);
    checkOutput("rstWriteValid", 32'(FPGA_WRITE_VALID_O), 32'd0);
    checkOutput("rstControlReady", 32'(CONTROL_READY_O), 32'd1);
    checkOutput("rstStatus", 32'(STATUS_O), 32'd0);
    checkOutput("rstData", DATA_O, 32'd0);
    checkOutput("rstTrigOut", 32'(FPGA_TRIG_O), 32'd0);
    checkOutput("rstStream", 32'(FPGA_STREAM_O), 32'd0);
    RST_NI = 1'b1;
    tick();

    FPGA_TRIG_I = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("idleTrigOut", 32'(FPGA_TRIG_O), 32'd0);
      checkOutput("idleWriteValid", 32'(FPGA_WRITE_VALID_O), 32'd0);
      checkOutput("idleStatusValid", 32'(STATUS_VALID_O), 32'd0);
    end
    FPGA_TRIG_I = 1'b0;

    runTrace(3'd0, DEPTH);
    readWords(DEPTH);
    checkOutput("dataValidEnd", 32'(DATA_VALID_O), 32'd0);
    checkOutput("statusValidHeld", 32'(STATUS_VALID_O), 32'd1);

    runTrace(3'd3, 5);
    readWords(DEPTH);
    checkOutput("dataValidEnd", 32'(DATA_VALID_O), 32'd0);

    runTrace(3'd7, DEPTH);
    readWords(5);
    expQ.delete();
    checkOutput("midDataValid", 32'(DATA_VALID_O), 32'd1);
    applyStimulus(6'b000110, 1'b1);
    checkOutput("midDataValidDrop", 32'(DATA_VALID_O), 32'd0);
    checkOutput("midStatusValidDrop", 32'(STATUS_VALID_O), 32'd0);
    checkOutput("midWriteValidRise", 32'(FPGA_WRITE_VALID_O), 32'd1);
    checkOutput("ctrlBeatsTrig", 32'(FPGA_TRIG_O), 32'd0);
    tick();
    checkOutput("ctrlBeatsTrigLate", 32'(FPGA_TRIG_O), 32'd0);

`ifdef STB_STREAM_MODE_EN
    applyStimulus(6'b000111, 1'b0);
    checkOutput("streamWriteValid", 32'(FPGA_WRITE_VALID_O), 32'd0);
    checkOutput("streamReady", 32'(DATA_READY_O), 32'd1);
    FPGA_READ_I = 1'b1;
    DATA_I = 32'h04030201;
    DATA_VALID_I = 1'b1;
    for (int b = 0; b < 4; b++) expQ.push_back(32'(DATA_I[b*8 +: 8]));
    #1;
    checkOutput("streamEmpty", 32'(FPGA_STREAM_O), 32'd0);
    tick();
    DATA_VALID_I = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      exp = (expQ.size() != 0) ? expQ.pop_front() : 32'd0;
      checkOutput("streamOut", 32'(FPGA_STREAM_O), exp);
      tick();
    end
    FPGA_READ_I = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      DATA_I = 32'h10203040 + 32'(i);
      DATA_VALID_I = 1'b1;
      #1;
      checkOutput("readyNotFull", 32'(DATA_READY_O), 32'd1);
      tick();
    end
    DATA_VALID_I = 1'b0;
    #1;
    checkOutput("readyFull", 32'(DATA_READY_O), 32'd0);
    FPGA_READ_I = 1'b1;
    #1;
    checkOutput("streamHead", 32'(FPGA_STREAM_O), 32'h40);
    checkOutput("readyFullMidWord", 32'(DATA_READY_O), 32'd0);
    repeat (3) tick();
    checkOutput("readyFullPop", 32'(DATA_READY_O), 32'd1);
    FPGA_READ_I = 1'b0;
`else
    applyStimulus(6'b000111, 1'b0);
    checkOutput("modeBitTrace", 32'(FPGA_WRITE_VALID_O), 32'd1);
    FPGA_READ_I = 1'b1;
    DATA_VALID_I = 1'b1;
    #1;
    checkOutput("noStreamReady", 32'(DATA_READY_O), 32'd0);
    checkOutput("noStreamOut", 32'(FPGA_STREAM_O), 32'd0);
    FPGA_READ_I = 1'b0;
    DATA_VALID_I = 1'b0;
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
